// File: rtl/pipe_pkg.sv
// Shared types and constants for the generic pipeline stage register.
package pipe_pkg;

    localparam int unsigned PIPE_INSTR_W = 16;
    localparam int unsigned PIPE_CTRL_W  = 8;
    localparam int unsigned PIPE_DATA_W  = 16;
    localparam int unsigned PIPE_NDATA   = 3;
    localparam int unsigned PIPE_WORD_W  = PIPE_INSTR_W + PIPE_CTRL_W + PIPE_NDATA * PIPE_DATA_W;

    localparam logic [PIPE_INSTR_W-1:0] NOP_INSTR = 16'h0800;

    // Bit positions inside the control bundle
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMWRITE = 1;
    localparam int unsigned CTRL_MEMEN    = 2;
    localparam int unsigned CTRL_MEMTOREG = 3;
    localparam int unsigned CTRL_DUMP     = 4;
    localparam int unsigned CTRL_REGDST   = 5;
    localparam int unsigned CTRL_REGDST_W = 2;

    typedef struct packed {
        logic [PIPE_INSTR_W-1:0]           instr;
        logic [PIPE_CTRL_W-1:0]            ctrl;
        logic [PIPE_NDATA*PIPE_DATA_W-1:0] data;
    } pipe_word_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skidState_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry (main + skid) storage whose ready is decoded purely from registered state,
// so there is no combinational path from outReady to inReady.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned WORD_W = PIPE_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [WORD_W-1:0] inWord,
    input  logic              outReady,
    output logic              outValid,
    output logic [WORD_W-1:0] outWord
);

    skidState_t        stateQ;
    skidState_t        stateNext;
    logic              loadMain;
    logic              loadSkid;
    logic              mainFromSkid;
    logic [WORD_W-1:0] mainQ;
    logic [WORD_W-1:0] skidQ;

    assign inReady  = (stateQ != SKID_TWO);
    assign outValid = (stateQ != SKID_EMPTY);
    assign outWord  = mainQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= SKID_EMPTY;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Occupancy transitions; inValid implies acceptance in EMPTY/ONE since ready is high there
    always_comb begin
        stateNext    = stateQ;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        case (stateQ)
            SKID_EMPTY: begin
                if (inValid) begin
                    loadMain  = 1'b1;
                    stateNext = SKID_ONE;
                end
            end
            SKID_ONE: begin
                if (outReady) begin
                    if (inValid) begin
                        loadMain = 1'b1;
                    end else begin
                        stateNext = SKID_EMPTY;
                    end
                end else if (inValid) begin
                    loadSkid  = 1'b1;
                    stateNext = SKID_TWO;
                end
            end
            SKID_TWO: begin
                if (outReady) begin
                    mainFromSkid = 1'b1;
                    stateNext    = SKID_ONE;
                end
            end
            default: stateNext = SKID_EMPTY;
        endcase
        if (flush) begin
            stateNext = SKID_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            if (loadMain) begin
                mainQ <= inWord;
            end else if (mainFromSkid) begin
                mainQ <= skidQ;
            end
            if (loadSkid) begin
                skidQ <= inWord;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline stage register with flush, bubble masking and a stall counter.
// Build option: PIPE_SKID_EN selects the registered-ready two-entry skid buffer.
module pipe_stage_hs #(
    parameter int unsigned          INSTR_W   = 16,
    parameter int unsigned          CTRL_W    = 8,
    parameter int unsigned          DATA_W    = 16,
    parameter int unsigned          NDATA     = 3,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR),
    parameter int unsigned          CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSTR_W-1:0]      in_instr,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int unsigned DATAV_W = NDATA * DATA_W;
    localparam int unsigned WORD_W  = INSTR_W + CTRL_W + DATAV_W;

    logic [WORD_W-1:0] inWord;
    logic [WORD_W-1:0] mainWord;
    logic              mainValid;
    logic [CNT_W-1:0]  stallCntQ;

    assign inWord = {in_instr, in_ctrl, in_data};

`ifdef PIPE_SKID_EN
    pipe_skid_buf #(
        .WORD_W (WORD_W)
    ) uSkidBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .inWord   (inWord),
        .outReady (out_ready),
        .outValid (mainValid),
        .outWord  (mainWord)
    );
`else
    logic accept;

    assign in_ready = !mainValid | out_ready;
    assign accept   = in_valid & in_ready;

    // Single slot: flush discards both the held word and anything accepted this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid <= 1'b0;
            mainWord  <= '0;
        end else if (flush) begin
            mainValid <= 1'b0;
        end else if (accept) begin
            mainValid <= 1'b1;
            mainWord  <= inWord;
        end else if (out_ready) begin
            mainValid <= 1'b0;
        end
    end
`endif

    // Bubbles always look like NOPs downstream, whatever the storage holds
    assign out_valid = mainValid;
    assign out_instr = mainValid ? mainWord[WORD_W-1 -: INSTR_W] : NOP_INSTR;
    assign out_ctrl  = mainValid ? mainWord[DATAV_W +: CTRL_W] : '0;
    assign out_data  = mainWord[DATAV_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= '0;
        end else if (mainValid && !out_ready && (stallCntQ != '1)) begin
            stallCntQ <= stallCntQ + CNT_W'(1);
        end
    end

    assign stall_cnt = stallCntQ;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Randomized and directed bench for pipe_stage_hs against a queue-based stage model.
module tb_pipe_stage_hs;
    import pipe_pkg::*;

    localparam int unsigned CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [7:0]  in_ctrl = '0;
    logic [47:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [7:0]  out_ctrl;
    logic [47:0] out_data;
    logic [CNT_W-1:0] stall_cnt;

    int unsigned checkCnt = 0;
    int unsigned errCnt = 0;

    pipe_word_t       q[$];
    logic [CNT_W-1:0] mCnt = '0;
    int unsigned      nextInstr = 1;
    logic             seen6 = 1'b0;
    logic             seen7 = 1'b0;

    pipe_stage_hs #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Capacity 2 with registered ready, or capacity 1 with pass-through ready
    function automatic logic modelReady(input logic rdy);
`ifdef PIPE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || rdy;
`endif
    endfunction

    task automatic checkOutputs();
        if (q.size() > 0) begin
            checkEq("out_valid", 64'(out_valid), 64'(1'b1));
            checkEq("out_instr", 64'(out_instr), 64'(q[0].instr));
            checkEq("out_ctrl", 64'(out_ctrl), 64'(q[0].ctrl));
            checkEq("out_data", 64'(out_data), 64'(q[0].data));
        end else begin
            checkEq("out_valid", 64'(out_valid), 64'(1'b0));
            checkEq("out_instr", 64'(out_instr), 64'(16'h0800));
            checkEq("out_ctrl", 64'(out_ctrl), 64'(8'h00));
        end
        checkEq("stall_cnt", 64'(stall_cnt), 64'(mCnt));
        checkEq("in_ready", 64'(in_ready), 64'(modelReady(out_ready)));
    endtask

    // One clock: drive, check at negedge, advance the model, step past the edge
    task automatic cycle(input logic v, input logic rdy, input logic fl);
        pipe_word_t w;
        logic acc;
        w.instr = 16'(nextInstr);
        w.ctrl  = 8'($urandom);
        w.data  = {16'($urandom), 16'($urandom), 16'($urandom)};
        in_valid  = v;
        in_instr  = w.instr;
        in_ctrl   = w.ctrl;
        in_data   = w.data;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        checkOutputs();
        if (out_valid && out_instr == 16'd6) seen6 = 1'b1;
        if (out_valid && out_instr == 16'd7) seen7 = 1'b1;
        acc = v && modelReady(rdy);
        if (q.size() > 0 && !rdy && mCnt != 4'hF) mCnt++;
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (acc) q.push_back(w);
        end
        if (acc) nextInstr++;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        mCnt = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        doReset();

        // Reset mid-stream clears outputs asynchronously
        nextInstr = 1;
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        checkEq("pre_rst_valid", 64'(out_valid), 64'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        checkEq("rst_valid", 64'(out_valid), 64'(1'b0));
        checkEq("rst_instr", 64'(out_instr), 64'(16'h0800));
        checkEq("rst_ctrl", 64'(out_ctrl), 64'(8'h00));
        checkEq("rst_data", 64'(out_data), 64'(48'h0));
        checkEq("rst_stall", 64'(stall_cnt), 64'(4'h0));
        doReset();

        // Streaming 8 words back to back
        nextInstr = 1;
        repeat (8) cycle(1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0);

        // Backpressure with word 3 held for 5 cycles
        doReset();
        nextInstr = 1;
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        checkEq("bp_stall", 64'(stall_cnt), 64'(4'd5));
        checkEq("bp_instr", 64'(out_instr), 64'(16'd3));
        repeat (4) cycle(1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0);

        // Flush while word 6 is being accepted
        doReset();
        nextInstr = 5;
        seen6 = 1'b0;
        seen7 = 1'b0;
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        flush = 1'b0;
        #1;
        checkEq("fl_valid", 64'(out_valid), 64'(1'b0));
        checkEq("fl_instr", 64'(out_instr), 64'(16'h0800));
        checkEq("fl_ctrl", 64'(out_ctrl), 64'(8'h00));
        cycle(1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0);
        checkEq("fl_no6", 64'(seen6), 64'(1'b0));
        checkEq("fl_saw7", 64'(seen7), 64'(1'b1));

        // Flush during stall empties everything
        doReset();
        nextInstr = 20;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        in_valid = 1'b0;
        flush = 1'b0;
        #1;
        checkEq("fs_ready", 64'(in_ready), 64'(1'b1));
        checkEq("fs_valid", 64'(out_valid), 64'(1'b0));
        cycle(1'b0, 1'b1, 1'b0);

        // Stall counter saturation
        doReset();
        nextInstr = 30;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        checkEq("sat_stall", 64'(stall_cnt), 64'(4'hF));
        cycle(1'b0, 1'b1, 1'b0);

        // Random traffic
        doReset();
        nextInstr = 100;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 70),
                  1'($urandom_range(0, 99) < 65),
                  1'($urandom_range(0, 99) < 5));
        end

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
